// File: rtl/pc16_stack.sv
// ---------------------------------------------------------------------------
// pc16_stack -- registered 16-bit Hack program counter with a hardware
// return-address stack.
//
// Ports (pc16_stack):
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset (clears PC, stack, depth, flags)
//   in[15:0]   jump / call target address
//   load       PC <- in
//   inc        PC <- PC + 1
//   call       push PC + 1, then PC <- in
//   ret        PC <- popped return address
//   out[15:0]  current PC (registered), instruction-ROM address
//   top[15:0]  current top-of-stack entry, 0 when the stack is empty
//   depth      number of valid stack entries
//   overflow   sticky: a call was issued while the stack was full
//   underflow  sticky: a ret was issued while the stack was empty
//
// Command interface: there is no valid/ready handshake. Every rising edge
// samples the command inputs and performs exactly one action chosen by the
// fixed priority reset > ret > call > load > inc > hold. The result is
// visible on out/depth/top/flags for the following cycle.
//
// inc16_gate is the single incrementer for the PC path; it lives in this
// file so the block stays self-contained.
// ---------------------------------------------------------------------------

// inc16_gate: out = in + 1 (mod 2^16).
//   in[15:0]   operand
//   out[15:0]  operand plus one, wrapping FFFF -> 0000
module inc16_gate (
  input  logic [15:0] in,
  output logic [15:0] out
);
  assign out = in + 16'd1;
endmodule

module pc16_stack #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [15:0]                in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  output logic [15:0]                out,
  output logic [15:0]                top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   pc_q;
  logic [15:0]   pc_plus1;
  logic [DW-1:0] depth_q;
  logic          ovf_q;
  logic          unf_q;
  logic [15:0]   stack [DEPTH];

  logic          empty;
  logic          full;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] pop_idx;

  inc16_gate u_inc (
    .in  (pc_q),
    .out (pc_plus1)
  );

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DW'(DEPTH));
  // push_idx is only used when not full, so depth fits in AW bits;
  // pop_idx is only used when not empty, so depth-1 does not underflow.
  assign push_idx = depth_q[AW-1:0];
  assign pop_idx  = AW'(depth_q - DW'(1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= 16'h0000;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= 16'h0000;
      end
    end else if (ret) begin
      if (empty) begin
        unf_q <= 1'b1;
      end else begin
        pc_q    <= stack[pop_idx];
        depth_q <= depth_q - DW'(1);
      end
    end else if (call) begin
      // The jump is taken even when the push has to be dropped.
      pc_q <= in;
      if (full) begin
        ovf_q <= 1'b1;
      end else begin
        stack[push_idx] <= pc_plus1;
        depth_q         <= depth_q + DW'(1);
      end
    end else if (load) begin
      pc_q <= in;
    end else if (inc) begin
      pc_q <= pc_plus1;
    end
  end

  assign out       = pc_q;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign top       = empty ? 16'h0000 : stack[pop_idx];

endmodule

// File: tb/tb_pc16_stack.sv
// ---------------------------------------------------------------------------
// tb_pc16_stack -- directed bench for pc16_stack (DEPTH = 8).
// The driver applies one command per cycle at the falling edge and pushes the
// hand-computed post-edge state into exp_q; the monitor pops one entry after
// every rising edge and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pc16_stack;

  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int W     = 16 + DW + 16 + 2;

  logic          clk;
  logic          reset_n;
  logic [15:0]   in;
  logic          load, inc, call, ret;
  logic [15:0]   out;
  logic [15:0]   top;
  logic [DW-1:0] depth;
  logic          overflow, underflow;

  logic [W-1:0]  exp_q[$];
  string         name_q[$];
  int            checks;
  int            failures;

  pc16_stack #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in),
    .load      (load),
    .inc       (inc),
    .call      (call),
    .ret       (ret),
    .out       (out),
    .top       (top),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // One cycle: apply inputs at the falling edge, record expected state after
  // the next rising edge.
  task automatic step(input string nm, input logic rn, input logic ld,
                      input logic ic, input logic cl, input logic rt,
                      input logic [15:0] iv, input logic [15:0] eo,
                      input int ed, input logic [15:0] et,
                      input logic eov, input logic eun);
    @(negedge clk);
    reset_n = rn;
    load    = ld;
    inc     = ic;
    call    = cl;
    ret     = rt;
    in      = iv;
    exp_q.push_back({eo, DW'(ed), et, eov, eun});
    name_q.push_back(nm);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    string        nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {out, depth, top, overflow, underflow};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL %s: got out=%h depth=%0d top=%h ovf=%b unf=%b, expected out=%h depth=%0d top=%h ovf=%b unf=%b",
                   nm, a[W-1 -: 16], a[W-17 -: DW], a[17:2], a[1], a[0],
                   e[W-1 -: 16], e[W-17 -: DW], e[17:2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wait_cyc;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    load = 0; inc = 0; call = 0; ret = 0;
    in = 16'h0000;

    //    name         rn ld ic cl rt in       out     d  top     ov un
    // Reset then increment
    step("reset0",     0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
    step("reset1",     0, 0, 1, 1, 0, 16'h0055, 16'h0000, 0, 16'h0000, 0, 0);
    step("inc1",       1, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 16'h0000, 0, 0);
    step("inc2",       1, 0, 1, 0, 0, 16'h0000, 16'h0002, 0, 16'h0000, 0, 0);
    step("inc3",       1, 0, 1, 0, 0, 16'h0000, 16'h0003, 0, 16'h0000, 0, 0);
    step("hold",       1, 0, 0, 0, 0, 16'h9999, 16'h0003, 0, 16'h0000, 0, 0);
    // Load and wrap
    step("load_fffe",  1, 1, 0, 0, 0, 16'hFFFE, 16'hFFFE, 0, 16'h0000, 0, 0);
    step("inc_ffff",   1, 0, 1, 0, 0, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0);
    step("inc_wrap",   1, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
    // Call at FFFF pushes 0000
    step("load_ffff",  1, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 0, 0);
    step("call_wrap",  1, 0, 0, 1, 0, 16'h0050, 16'h0050, 1, 16'h0000, 0, 0);
    step("ret_wrap",   1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
    // Nested call/ret
    step("load_0010",  1, 1, 0, 0, 0, 16'h0010, 16'h0010, 0, 16'h0000, 0, 0);
    step("call_0100",  1, 0, 0, 1, 0, 16'h0100, 16'h0100, 1, 16'h0011, 0, 0);
    step("call_0200",  1, 0, 0, 1, 0, 16'h0200, 16'h0200, 2, 16'h0101, 0, 0);
    step("ret_a",      1, 0, 0, 0, 1, 16'h0000, 16'h0101, 1, 16'h0011, 0, 0);
    step("ret_b",      1, 0, 0, 0, 1, 16'h0000, 16'h0011, 0, 16'h0000, 0, 0);
    // Overflow: fill from out=0011
    step("ovf_call1",  1, 0, 0, 1, 0, 16'h0040, 16'h0040, 1, 16'h0012, 0, 0);
    for (int k = 2; k <= DEPTH; k++)
      step("ovf_fill", 1, 0, 0, 1, 0, 16'h0040, 16'h0040, k, 16'h0041, 0, 0);
    step("ovf_call9",  1, 0, 0, 1, 0, 16'h0040, 16'h0040, DEPTH, 16'h0041, 1, 0);
    // Full stack, different PC: a dropped push must not touch the top entry
    step("ovf_load",   1, 1, 0, 0, 0, 16'h0123, 16'h0123, DEPTH, 16'h0041, 1, 0);
    step("ovf_drop",   1, 0, 0, 1, 0, 16'h0040, 16'h0040, DEPTH, 16'h0041, 1, 0);
    for (int k = 1; k <= DEPTH - 2; k++)
      step("lifo_ret", 1, 0, 0, 0, 1, 16'h0000, 16'h0041, DEPTH - k, 16'h0041, 1, 0);
    step("lifo_ret7",  1, 0, 0, 0, 1, 16'h0000, 16'h0041, 1, 16'h0012, 1, 0);
    step("lifo_ret8",  1, 0, 0, 0, 1, 16'h0000, 16'h0012, 0, 16'h0000, 1, 0);
    // Underflow and priority
    step("unf_ret",    1, 0, 0, 0, 1, 16'h0000, 16'h0012, 0, 16'h0000, 1, 1);
    step("call_0300",  1, 0, 0, 1, 0, 16'h0300, 16'h0300, 1, 16'h0013, 1, 1);
    step("call_ret",   1, 0, 0, 1, 1, 16'h0777, 16'h0013, 0, 16'h0000, 1, 1);
    step("load_inc",   1, 1, 1, 0, 0, 16'h1234, 16'h1234, 0, 16'h0000, 1, 1);
    // Reset mid-sequence with depth=3
    step("call_0500",  1, 0, 0, 1, 0, 16'h0500, 16'h0500, 1, 16'h1235, 1, 1);
    step("call_0600",  1, 0, 0, 1, 0, 16'h0600, 16'h0600, 2, 16'h0501, 1, 1);
    step("call_0700",  1, 0, 0, 1, 0, 16'h0700, 16'h0700, 3, 16'h0601, 1, 1);
    step("rst_call",   0, 0, 0, 1, 0, 16'h0800, 16'h0000, 0, 16'h0000, 0, 0);
    step("post_rst",   1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
    // Back-to-back call/ret
    step("b2b_call",   1, 0, 0, 1, 0, 16'h0010, 16'h0010, 1, 16'h0001, 0, 0);
    step("b2b_ret",    1, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 16'h0000, 0, 0);
    step("post_unf",   1, 0, 0, 0, 1, 16'h0000, 16'h0001, 0, 16'h0000, 0, 1);

    @(negedge clk);
    load = 0; inc = 0; call = 0; ret = 0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
